deserializador_phy: RTL and testbench

Serial-to-parallel receive end of the PHY link. Samples the serial stream at `clk_32f`, aligns to the 0xBC comma, declares lock after four consecutive commas and reassembles 32-bit words from data bytes, discarding 0x7C idle bytes. Outputs `data_out`, `valid_out` and `active_out` to the lane-unstriping stage, mirroring the `data_input`/`valid`/`active` contract on the transmit side.

---
 rtl/deserializador_phy_pkg.sv | 12 +
 rtl/deserializador_phy_if.sv | 17 +
 rtl/deserializador_phy_alineador_bytes.sv | 74 +++++++
 rtl/deserializador_phy.sv | 62 ++++++
 tb/tb_deserializador_phy.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/deserializador_phy_pkg.sv
// Shared constants and state encoding for the PHY receive path.
package phy_rx_pkg;
  localparam logic [7:0] COMMA_DEF      = 8'hBC;
  localparam logic [7:0] IDLE_DEF       = 8'h7C;
  localparam int         LOCK_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;
endpackage

// File: rtl/deserializador_phy_if.sv
// Serial input and word-level output bundle of the PHY receiver.
interface deserializador_phy_if;
  logic        data_serial;
  logic        active_out;
  logic        valid_out;
  logic [31:0] data_out;
  logic        error_out;

  modport master (
    input  data_serial,
    output active_out, valid_out, data_out, error_out
  );
  modport slave (
    output data_serial,
    input  active_out, valid_out, data_out, error_out
  );
endinterface

// File: rtl/deserializador_phy_alineador_bytes.sv
// Bit-level comma hunt, byte alignment and lock tracking.
module alineador_bytes
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEF,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_serial,
  output logic       byte_strobe,
  output logic [7:0] byte_val,
  output logic       locked
);
  localparam logic [3:0] LOCK_N = LOCK_COUNT[3:0];

  rx_state_e  state;
  logic [7:0] sr;
  logic [7:0] nb;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic [3:0] bc_nxt;
  logic       byte_done;

  // The byte completing on this edge is judged before it lands in sr.
  assign nb          = {sr[6:0], data_serial};
  assign byte_val    = nb;
  assign byte_done   = (bit_cnt == 3'd7);
  assign byte_strobe = (state == LOCKED) && byte_done;
  assign bc_nxt      = (bc_cnt == 4'hF) ? bc_cnt : bc_cnt + 4'd1;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state   <= HUNT;
      sr      <= 8'h00;
      bit_cnt <= 3'd0;
      bc_cnt  <= 4'd0;
      locked  <= 1'b0;
    end else begin
      sr <= nb;
      case (state)
        HUNT: begin
          if (nb == COMMA) begin
            bit_cnt <= 3'd0;
            bc_cnt  <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (nb == COMMA) begin
              bc_cnt <= bc_nxt;
              if (bc_nxt >= LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              state  <= HUNT;
              bc_cnt <= 4'd0;
            end
          end
        end
        LOCKED: bit_cnt <= bit_cnt + 3'd1;
        default: state <= HUNT;
      endcase
    end
  end
endmodule

// File: rtl/deserializador_phy.sv
// PHY receive top: aligned bytes in, 32-bit words out; idles dropped,
// a comma mid-word aborts the partial word with an error pulse.
module deserializador_phy
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEF,
  parameter logic [7:0] IDLE       = IDLE_DEF,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic                        clk_32f,
  input  logic                        reset,
  deserializador_phy_if.master        rx
);
  logic        byte_strobe;
  logic [7:0]  byte_val;
  logic        locked;
  logic [1:0]  byte_idx;
  logic [23:0] word;

  alineador_bytes #(
    .COMMA      (COMMA),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_alineador (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_serial (rx.data_serial),
    .byte_strobe (byte_strobe),
    .byte_val    (byte_val),
    .locked      (locked)
  );

  assign rx.active_out = locked;

  // Only the three most recent data bytes matter; the 4th goes straight out.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      byte_idx     <= 2'd0;
      word         <= 24'h0;
      rx.data_out  <= 32'h0;
      rx.valid_out <= 1'b0;
      rx.error_out <= 1'b0;
    end else begin
      rx.valid_out <= 1'b0;
      rx.error_out <= 1'b0;
      if (byte_strobe) begin
        if (byte_val == COMMA) begin
          rx.error_out <= (byte_idx != 2'd0);
          byte_idx     <= 2'd0;
        end else if (byte_val != IDLE) begin
          word <= {word[15:0], byte_val};
          if (byte_idx == 2'd3) begin
            rx.data_out  <= {word, byte_val};
            rx.valid_out <= 1'b1;
            byte_idx     <= 2'd0;
          end else begin
            byte_idx <= byte_idx + 2'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_deserializador_phy.sv
// Directed bench for deserializador_phy with a pulse scoreboard.
module tb_deserializador_phy;
  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  deserializador_phy_if rx();

  deserializador_phy dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .rx      (rx)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx.data_serial = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic expect_word(input logic [31:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [31:0] d_held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = d_held;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " active_out"}, 32'(rx.active_out), 32'h0);
    check({tag, " valid_out"},  32'(rx.valid_out),  32'h0);
    check({tag, " error_out"},  32'(rx.error_out),  32'h0);
    check({tag, " data_out"},   rx.data_out,        32'h0);
  endtask

  // Monitor: every pulse must match the next scoreboard entry.
  always @(negedge clk_32f) begin
    if (rx.valid_out || rx.error_out) begin
      if (rx.valid_out && rx.error_out) begin
        n_tests++;
        n_fail++;
        $display("FAIL pulse overlap: valid_out and error_out both high");
      end
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected pulse: valid=%0b error=%0b data_out=%h, expected none",
                 rx.valid_out, rx.error_out, rx.data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse kind (error_out)", 32'(rx.error_out), 32'(e.is_err));
        check("pulse data_out", rx.data_out, e.data);
      end
    end
  end

  initial begin
    rx.data_serial = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(logic'(i[0]));
    check_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 32; i++) send_bit(1'b0);
    check("zeros active_out", 32'(rx.active_out), 32'h0);

    // 101 then four commas: lock lands on bit 35
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    for (int i = 7; i >= 1; i--) begin
      logic [7:0] c;
      c = 8'hBC;
      send_bit(c[i]);
    end
    check("lock bit34 active_out", 32'(rx.active_out), 32'h0);
    send_bit(1'b0);
    check("lock bit35 active_out", 32'(rx.active_out), 32'h1);

    expect_word(32'hADFEBA01);
    send_byte(8'hAD); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'h01);
    check("word1 valid on last bit", 32'(rx.valid_out), 32'h1);
    expect_word(32'hFFEEEEEE);
    send_byte(8'hFF); send_byte(8'hEE); send_byte(8'hEE); send_byte(8'hEE);

    expect_word(32'hFAFAFA01);
    send_byte(8'hFA); send_byte(8'h7C); send_byte(8'hFA);
    send_byte(8'h7C); send_byte(8'hFA); send_byte(8'h01);

    expect_err(32'hFAFAFA01);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hBC);
    check("abort error_out", 32'(rx.error_out), 32'h1);
    check("abort data_out held", rx.data_out, 32'hFAFAFA01);
    check("abort still active", 32'(rx.active_out), 32'h1);

    expect_word(32'h12345678);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);

    // reset in the middle of a byte
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1;
    send_bit(1'b1);
    reset = 1'b0;
    check_zero("mid-byte reset");

    // three commas then a data byte falls back to HUNT
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    send_byte(8'h55);
    check("align abort active_out", 32'(rx.active_out), 32'h0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    check("relock 3 commas active_out", 32'(rx.active_out), 32'h0);
    send_byte(8'hBC);
    check("relock active_out", 32'(rx.active_out), 32'h1);

    expect_word(32'hCAFE0042);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h42);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
